// File: rtl/fp_pipe_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pipe_pkg
// Description : Shared widths, opcodes, test constants and a popcount helper
//               for the FP pipeline trackers.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pipe_pkg;

  localparam int FP_W        = 32;
  localparam int STATS_W     = 16;
  localparam int INFLIGHT_W  = 6;
  localparam int MAX_LATENCY = 32;

  localparam logic FP_OP_ADD = 1'b1;
  localparam logic FP_OP_SUB = 1'b0;

  localparam logic [FP_W-1:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_TWO   = 32'h4000_0000;
  localparam logic [FP_W-1:0] FP_THREE = 32'h4040_0000;

  typedef logic [FP_W-1:0] fp_word_t;

  function automatic logic [INFLIGHT_W-1:0] count_ones(input logic [MAX_LATENCY-1:0] bits);
    logic [INFLIGHT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_LATENCY; i++) begin
      acc = acc + INFLIGHT_W'(bits[i]);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_pipe_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_pipe_tracker_if
// Description : Operation stream, result stream and FP core bus of the
//               tracker. slave = tracker side, master = caller/core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_pipe_tracker_if
  import fp_pipe_pkg::*;
#(
  parameter int DATA_W = FP_W,
  parameter int TAG_W  = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic              in_add_sub;
  logic [DATA_W-1:0] in_dataa;
  logic [DATA_W-1:0] in_datab;
  logic [TAG_W-1:0]  in_tag;

  logic              core_clk_en;
  logic              core_add_sub;
  logic [DATA_W-1:0] core_dataa;
  logic [DATA_W-1:0] core_datab;
  logic [DATA_W-1:0] core_result;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;

  logic              busy;

  modport slave (
    input  in_valid, in_add_sub, in_dataa, in_datab, in_tag,
    input  core_result, out_ready,
    output in_ready, core_clk_en, core_add_sub, core_dataa, core_datab,
    output out_valid, out_result, out_tag, busy
  );

  modport master (
    output in_valid, in_add_sub, in_dataa, in_datab, in_tag,
    output core_result, out_ready,
    input  in_ready, core_clk_en, core_add_sub, core_dataa, core_datab,
    input  out_valid, out_result, out_tag, busy
  );

endinterface
`default_nettype wire

// File: rtl/fp_pipe_tracker_tag_shift.sv
`default_nettype none
// ============================================================================
// Module      : fp_pipe_tag_shift
// Description : LATENCY-deep valid+tag delay line advancing only on en,
//               mirroring the occupancy of an enable-gated compute core.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_pipe_tag_shift #(
  parameter int LATENCY = 7,
  parameter int TAG_W   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [LATENCY-1:0] valid,
  output logic [TAG_W-1:0]   last_tag
);

  logic [LATENCY-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [LATENCY];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else if (en) begin
      r_valid[0] <= in_valid;
      r_tag[0]   <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign valid    = r_valid;
  assign last_tag = r_tag[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/fp_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module      : fp_pipe_tracker
// Description : Runs a fixed-latency FP add/sub core fully pipelined and
//               presents its results on a valid/ready stream; backpressure
//               freezes the core via clk_en. Optional FP_PIPE_STATS_EN adds
//               op_count and inflight outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_pipe_tracker
  import fp_pipe_pkg::*;
#(
  parameter int LATENCY = 7,
  parameter int DATA_W  = FP_W,
  parameter int TAG_W   = 4
) (
  input  logic clock,
  input  logic reset_n,
  fp_pipe_tracker_if.slave bus
`ifdef FP_PIPE_STATS_EN
  ,
  output logic [STATS_W-1:0]    op_count,
  output logic [INFLIGHT_W-1:0] inflight
`endif
);

  logic               w_advance;
  logic               w_capture;
  logic [LATENCY-1:0] w_valid;
  logic [TAG_W-1:0]   w_last_tag;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_result;
  logic [TAG_W-1:0]   r_out_tag;

  // Core, shadow line and output register all move on the same condition,
  // so accepting while full can never overflow.
  assign w_advance = !r_out_valid || bus.out_ready;
  assign w_capture = w_advance && w_valid[LATENCY-1];

  assign bus.in_ready     = w_advance;
  assign bus.core_clk_en  = w_advance;
  assign bus.core_add_sub = bus.in_add_sub;
  assign bus.core_dataa   = bus.in_dataa;
  assign bus.core_datab   = bus.in_datab;

  fp_pipe_tag_shift #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_tag_shift (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (w_advance),
    .in_valid (bus.in_valid),
    .in_tag   (bus.in_tag),
    .valid    (w_valid),
    .last_tag (w_last_tag)
  );

  // A capture in the same edge as a drain overwrites the old result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= bus.core_result;
      r_out_tag    <= w_last_tag;
    end else if (bus.out_ready && r_out_valid) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_tag    = r_out_tag;
  assign bus.busy       = (|w_valid) || r_out_valid;

`ifdef FP_PIPE_STATS_EN
  logic [STATS_W-1:0] r_op_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op_count <= '0;
    end else if (r_out_valid && bus.out_ready) begin
      r_op_count <= r_op_count + STATS_W'(1);
    end
  end

  assign op_count = r_op_count;
  assign inflight = count_ones(MAX_LATENCY'(w_valid)) + INFLIGHT_W'(r_out_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_pipe_tracker
// Description : Self-checking bench for fp_pipe_tracker with a behavioural
//               FP core and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_pipe_tracker;
  import fp_pipe_pkg::*;

  localparam int L  = 7;
  localparam int DW = 32;
  localparam int TW = 4;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          k;
    int          cyc;
  } op_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fp_pipe_tracker_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

`ifdef FP_PIPE_STATS_EN
  logic [15:0] op_count;
  logic [5:0]  inflight;
`endif

  fp_pipe_tracker #(.LATENCY(L), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FP_PIPE_STATS_EN
    ,
    .op_count (op_count),
    .inflight (inflight)
`endif
  );

  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  int          adv_edges = 0;
  logic [15:0] hs_cnt = 16'h0;
  op_t         q[$];
  op_t         done_q[$];

  function automatic real sp2r(input logic [31:0] s);
    logic [63:0] d;
    logic [10:0] e;
    if (s[30:0] == 31'h0) return 0.0;
    e = 11'({3'b000, s[30:23]}) + 11'd896;
    d = {s[31], e, s[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    return op ? r2sp(sp2r(a) + sp2r(b)) : r2sp(sp2r(a) - sp2r(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return r2sp(real'($urandom_range(0, 1000)));
  endfunction

  // Behavioural core: LATENCY enabled edges deep, no reset.
  logic [31:0] core_pipe [L];
  always @(posedge clock) begin
    if (bus.core_clk_en === 1'b1) begin
      for (int i = L - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
      core_pipe[0] <= fp_op(bus.core_add_sub, bus.core_dataa, bus.core_datab);
    end
  end
  assign bus.core_result = core_pipe[L-1];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference: an op accepted at advancing edge k is held at the output
  // once L further advancing edges have happened, until it is drained.
  task automatic monitor();
    logic exp_ov;
    logic exp_adv;
    op_t  e;
    if (!reset_n) begin
      q.delete();
      hs_cnt = 16'h0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
`ifdef FP_PIPE_STATS_EN
      check("rst_op_count", op_count, 0);
      check("rst_inflight", inflight, 0);
`endif
      return;
    end
    exp_ov  = (q.size() > 0) && (q[0].k + L + 1 <= adv_edges);
    exp_adv = !exp_ov || bus.out_ready;
    check("out_valid", bus.out_valid, exp_ov);
    check("busy", bus.busy, q.size() > 0);
    check("in_ready", bus.in_ready, exp_adv);
    check("core_clk_en", bus.core_clk_en, exp_adv);
    if (bus.in_valid) begin
      check("core_dataa", bus.core_dataa, bus.in_dataa);
      check("core_datab", bus.core_datab, bus.in_datab);
      check("core_add_sub", bus.core_add_sub, bus.in_add_sub);
    end
    if (exp_ov) begin
      check("out_result", bus.out_result, q[0].res);
      check("out_tag", bus.out_tag, q[0].tag);
    end
`ifdef FP_PIPE_STATS_EN
    check("inflight", inflight, q.size());
    check("op_count", op_count, hs_cnt);
`endif
    if (exp_ov && bus.out_ready) begin
      e = q.pop_front();
      e.cyc = cyc_n;
      done_q.push_back(e);
      hs_cnt = hs_cnt + 16'h1;
    end
    if (exp_adv && bus.in_valid) begin
      e.res = fp_op(bus.in_add_sub, bus.in_dataa, bus.in_datab);
      e.tag = bus.in_tag;
      e.k   = adv_edges;
      e.cyc = cyc_n;
      q.push_back(e);
    end
    if (exp_adv) adv_edges++;
  endtask

  task automatic cyc();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    bus.in_valid   = 1'b1;
    bus.in_add_sub = op;
    bus.in_dataa   = a;
    bus.in_datab   = b;
    bus.in_tag     = t;
  endtask

  initial begin
    int          a;
    int          n;
    logic [31:0] r0;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.in_valid   = 1'b0;
    bus.in_add_sub = FP_OP_ADD;
    bus.in_dataa   = '0;
    bus.in_datab   = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    repeat (3) cyc();
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_result", bus.out_result, 0);
    check("reset_out_tag", bus.out_tag, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_in_ready", bus.in_ready, 1);
    reset_n = 1'b1;
    cyc();

    // Single op
    bus.out_ready = 1'b1;
    issue(FP_OP_ADD, FP_ONE, FP_TWO, 4'd5);
    cyc();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      cyc();
      n++;
    end
    check("single_latency", n, L + 1);
    check("single_result", bus.out_result, FP_THREE);
    check("single_tag", bus.out_tag, 5);
    cyc();
    check("single_busy_after", bus.busy, 0);
    check("single_valid_after", bus.out_valid, 0);

    // Back-to-back
    done_q.delete();
    a = cyc_n;
    for (int i = 0; i < 10; i++) begin
      issue(FP_OP_ADD, rand_fp(), rand_fp(), 4'(i));
      check("b2b_in_ready", bus.in_ready, 1);
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (15) cyc();
    check("b2b_count", done_q.size(), 10);
    for (int i = 0; i < 10 && i < done_q.size(); i++) begin
      check("b2b_tag", done_q[i].tag, i);
      check("b2b_cycle", done_q[i].cyc, a + L + 1 + i);
    end

    // Backpressure
    done_q.delete();
    ra = rand_fp();
    rb = rand_fp();
    r0 = fp_op(FP_OP_SUB, ra, rb);
    issue(FP_OP_SUB, ra, rb, 4'd3);
    cyc();
    issue(FP_OP_ADD, rand_fp(), rand_fp(), 4'd4);
    cyc();
    issue(FP_OP_ADD, rand_fp(), rand_fp(), 4'd5);
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      cyc();
      n++;
    end
    check("bp_reached", bus.out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_clk_en", bus.core_clk_en, 0);
      check("bp_held_result", bus.out_result, r0);
      check("bp_held_tag", bus.out_tag, 3);
      cyc();
    end
    bus.out_ready = 1'b1;
    repeat (12) cyc();
    check("bp_count", done_q.size(), 3);
    for (int i = 0; i < 3 && i < done_q.size(); i++) begin
      check("bp_order", done_q[i].tag, 3 + i);
    end

    // Subtract and bubbles
    done_q.delete();
    a = cyc_n;
    issue(FP_OP_SUB, FP_THREE, FP_ONE, 4'd1);
    cyc();
    bus.in_valid = 1'b0;
    repeat (2) cyc();
    issue(FP_OP_ADD, FP_TWO, FP_TWO, 4'd2);
    cyc();
    bus.in_valid = 1'b0;
    repeat (15) cyc();
    check("bub_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("bub_sub_result", done_q[0].res, 32'h4000_0000);
      check("bub_add_result", done_q[1].res, 32'h4080_0000);
      check("bub_first_cycle", done_q[0].cyc, a + L + 1);
      check("bub_gap", done_q[1].cyc - done_q[0].cyc, 3);
    end

    // Reset mid-flight
    for (int i = 0; i < 4; i++) begin
      issue(FP_OP_ADD, rand_fp(), rand_fp(), 4'(10 + i));
      cyc();
    end
    bus.in_valid = 1'b0;
    check("rstmid_busy_before", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_valid", bus.out_valid, 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    done_q.delete();
    issue(FP_OP_ADD, FP_ONE, FP_TWO, 4'd9);
    cyc();
    bus.in_valid = 1'b0;
    repeat (15) cyc();
    check("rstmid_count", done_q.size(), 1);
    if (done_q.size() == 1) begin
      check("rstmid_tag", done_q[0].tag, 9);
      check("rstmid_result", done_q[0].res, FP_THREE);
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), rand_fp(), rand_fp(), 4'($urandom));
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) cyc();
    check("rand_drained", q.size(), 0);

`ifdef FP_PIPE_STATS_EN
    // Counter wrap
    n = int'(16'hFFFE - hs_cnt);
    for (int i = 0; i < n; i++) begin
      issue(FP_OP_ADD, rand_fp(), rand_fp(), 4'(i));
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (12) cyc();
    check("stats_preload", op_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      issue(FP_OP_ADD, FP_ONE, FP_ONE, 4'(i));
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (12) cyc();
    check("stats_wrap", op_count, 16'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
